// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: state codes,
// ALU operation codes, opcode/funct constants and the registered control bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_WB_R     = 4'd4,
    ST_EXEC_I   = 4'd5,
    ST_WB_I     = 4'd6,
    ST_MEM_ADDR = 4'd7,
    ST_MEM_RD   = 4'd8,
    ST_MEM_WB   = 4'd9,
    ST_MEM_WR   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_HALT     = 4'd12
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_TRAP = 4'hF;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       halt;
    logic       mem_to_reg;
    logic       mem_write;
    logic       beq;
    logic       bne;
    logic [3:0] alu_op;
    logic       alu_src_b;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Bundle between the datapath (master: supplies IR fields and Resume) and the
// control unit (slave: returns the control strobes and its state code).
interface mc_ctrl_fsm_if;
  // No valid/ready pair: Op/Func are sampled only during DECODE, and Resume is
  // a level that the control unit consumes only while in HALT (one exit per entry).
  logic [5:0] Op;
  logic [5:0] Func;
  logic       Resume;
  logic       PcWrite;
  logic       IrWrite;
  logic       Halt;
  logic       MemtoReg;
  logic       MemWrite;
  logic       Beq;
  logic       Bne;
  logic [3:0] AluOP;
  logic       AluSrcB;
  logic       RegWrite;
  logic       RegDst;
  logic [3:0] State;

  modport master (
    output Op, Func, Resume,
    input  PcWrite, IrWrite, Halt, MemtoReg, MemWrite, Beq, Bne,
    input  AluOP, AluSrcB, RegWrite, RegDst, State
  );

  modport slave (
    input  Op, Func, Resume,
    output PcWrite, IrWrite, Halt, MemtoReg, MemWrite, Beq, Bne,
    output AluOP, AluSrcB, RegWrite, RegDst, State
  );
endinterface

// File: rtl/mc_alu_dec.sv
// Funct-field decoder: maps an R-type funct to its ALU operation and flags
// whether it is one of the supported arithmetic/logic functs.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] i_func,
  output logic [3:0] o_alu_op,
  output logic       o_legal
);

  always_comb begin
    o_alu_op = ALU_ADD;
    o_legal  = 1'b1;
    case (i_func)
      FN_ADD:  o_alu_op = ALU_ADD;
      FN_SUB:  o_alu_op = ALU_SUB;
      FN_AND:  o_alu_op = ALU_AND;
      FN_OR:   o_alu_op = ALU_OR;
      FN_SLT:  o_alu_op = ALU_SLT;
      default: o_legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM with registered Moore outputs and halt/resume.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap unsupported instructions into HALT.
module mc_ctrl_fsm
  import mc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_l,
  mc_ctrl_fsm_if.slave  bus
);

  state_t     r_state, w_next;
  logic [5:0] r_op, r_func, w_op, w_func;
  ctrl_t      r_ctrl, w_ctrl;
  logic [3:0] w_fn_alu;
  logic       w_fn_legal, w_is_syscall, w_supported;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic       r_illegal, w_illegal_next;
`endif

  mc_alu_dec u_alu_dec (
    .i_func   (w_func),
    .o_alu_op (w_fn_alu),
    .o_legal  (w_fn_legal)
  );

  always_comb begin
    // In DECODE the IR fields are used directly; afterwards the latched copies.
    w_op         = (r_state == ST_DECODE) ? bus.Op   : r_op;
    w_func       = (r_state == ST_DECODE) ? bus.Func : r_func;
    w_is_syscall = (w_op == OP_RTYPE) && (w_func == FN_SYSCALL);
    case (w_op)
      OP_RTYPE:                                w_supported = w_fn_legal | w_is_syscall;
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE:   w_supported = 1'b1;
      default:                                 w_supported = 1'b0;
    endcase

    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = ST_FETCH;
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: begin
        if (!w_supported) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          w_next = ST_HALT;
`else
          w_next = ST_FETCH;
`endif
        end else begin
          case (w_op)
            OP_RTYPE:       w_next = w_is_syscall ? ST_HALT : ST_EXEC_R;
            OP_ADDI:        w_next = ST_EXEC_I;
            OP_LW, OP_SW:   w_next = ST_MEM_ADDR;
            OP_BEQ, OP_BNE: w_next = ST_BRANCH;
            default:        w_next = ST_FETCH;
          endcase
        end
      end
      ST_EXEC_R:   w_next = ST_WB_R;
      ST_EXEC_I:   w_next = ST_WB_I;
      ST_MEM_ADDR: w_next = (w_op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   w_next = ST_MEM_WB;
      ST_WB_R, ST_WB_I, ST_MEM_WB, ST_MEM_WR, ST_BRANCH: w_next = ST_FETCH;
      ST_HALT:     w_next = bus.Resume ? ST_FETCH : ST_HALT;
      default:     w_next = ST_IDLE;
    endcase

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    w_illegal_next = r_illegal;
    if (r_state == ST_DECODE && !w_supported) w_illegal_next = 1'b1;
    else if (r_state == ST_HALT && bus.Resume) w_illegal_next = 1'b0;
`endif

    // Outputs are decoded from the next state so they register alongside State.
    w_ctrl = '0;
    case (w_next)
      ST_FETCH: begin
        w_ctrl.ir_write = 1'b1;
        w_ctrl.pc_write = 1'b1;
        w_ctrl.alu_op   = ALU_ADD;
      end
      ST_EXEC_R: w_ctrl.alu_op = w_fn_alu;
      ST_WB_R: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.alu_op    = w_fn_alu;
      end
      ST_EXEC_I, ST_MEM_ADDR, ST_MEM_RD: begin
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.alu_op    = ALU_ADD;
      end
      ST_WB_I: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.alu_op    = ALU_ADD;
      end
      ST_MEM_WR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.alu_op    = ALU_ADD;
      end
      ST_MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      ST_BRANCH: begin
        w_ctrl.beq    = (w_op == OP_BEQ);
        w_ctrl.bne    = (w_op == OP_BNE);
        w_ctrl.alu_op = ALU_SUB;
      end
      ST_HALT: begin
        w_ctrl.halt = 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        if (w_illegal_next) w_ctrl.alu_op = ALU_TRAP;
`endif
      end
      default: w_ctrl = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_func  <= '0;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= w_ctrl;
      if (r_state == ST_DECODE) begin
        r_op   <= bus.Op;
        r_func <= bus.Func;
      end
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_illegal <= 1'b0;
    else        r_illegal <= w_illegal_next;
  end
`endif

  assign bus.PcWrite  = r_ctrl.pc_write;
  assign bus.IrWrite  = r_ctrl.ir_write;
  assign bus.Halt     = r_ctrl.halt;
  assign bus.MemtoReg = r_ctrl.mem_to_reg;
  assign bus.MemWrite = r_ctrl.mem_write;
  assign bus.Beq      = r_ctrl.beq;
  assign bus.Bne      = r_ctrl.bne;
  assign bus.AluOP    = r_ctrl.alu_op;
  assign bus.AluSrcB  = r_ctrl.alu_src_b;
  assign bus.RegWrite = r_ctrl.reg_write;
  assign bus.RegDst   = r_ctrl.reg_dst;
  assign bus.State    = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-instruction expected cycle traces
// are built from the instruction's documented state sequence and compared cycle by cycle.
module tb_mc_ctrl_fsm;
  import mc_pkg::*;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;

  mc_ctrl_fsm_if bus ();

  mc_ctrl_fsm dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, halt, m2r, mw, beq, bne;
    logic [3:0] alu;
    logic       srcb, rw, rd;
  } vec_t;

  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [17:0] mk(input int st, input bit pcw, input bit irw,
                                     input bit halt, input bit m2r, input bit mw,
                                     input bit beq, input bit bne, input int alu,
                                     input bit srcb, input bit rw, input bit rd);
    vec_t v;
    v.st = st[3:0]; v.pcw = pcw; v.irw = irw; v.halt = halt; v.m2r = m2r;
    v.mw = mw; v.beq = beq; v.bne = bne; v.alu = alu[3:0];
    v.srcb = srcb; v.rw = rw; v.rd = rd;
    return v;
  endfunction

  function automatic logic [17:0] fetch_v();
    return mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [17:0] observe();
    vec_t v;
    v.st = bus.State; v.pcw = bus.PcWrite; v.irw = bus.IrWrite; v.halt = bus.Halt;
    v.m2r = bus.MemtoReg; v.mw = bus.MemWrite; v.beq = bus.Beq; v.bne = bus.Bne;
    v.alu = bus.AluOP; v.srcb = bus.AluSrcB; v.rw = bus.RegWrite; v.rd = bus.RegDst;
    return v;
  endfunction

  // Reference: the cycle-by-cycle trace an instruction must produce after its FETCH.
  // Returns 1 when the trace ends in HALT instead of the next FETCH.
  function automatic bit model_push(input logic [5:0] op, input logic [5:0] fn);
    bit arith, sysc;
    int alu;
    arith = (op == OP_RTYPE) && (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
    sysc  = (op == OP_RTYPE) && (fn == FN_SYSCALL);
    alu   = (fn == FN_SUB) ? 1 : (fn == FN_AND) ? 2 : (fn == FN_OR) ? 3 : (fn == FN_SLT) ? 4 : 0;
    exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (arith) begin
      exp_q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, alu, 0, 0, 0));
      exp_q.push_back(mk(4, 0, 0, 0, 0, 0, 0, 0, alu, 0, 1, 1));
    end else if (sysc) begin
      exp_q.push_back(mk(12, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      return 1'b1;
    end else if (op == OP_ADDI) begin
      exp_q.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      exp_q.push_back(mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    end else if (op == OP_LW) begin
      exp_q.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      exp_q.push_back(mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      exp_q.push_back(mk(9, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    end else if (op == OP_SW) begin
      exp_q.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      exp_q.push_back(mk(10, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    end else if (op == OP_BEQ || op == OP_BNE) begin
      exp_q.push_back(mk(11, 0, 0, 0, 0, 0, op == OP_BEQ, op == OP_BNE, 1, 0, 0, 0));
    end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      exp_q.push_back(mk(12, 0, 0, 1, 0, 0, 0, 0, 15, 0, 0, 0));
      return 1'b1;
`endif
    end
    exp_q.push_back(fetch_v());
    return 1'b0;
  endfunction

  task automatic wait_fetch();
    for (int k = 0; k < 40; k++) begin
      if (bus.State == 4'd1) begin
        bus.Resume = 1'b0;
        return;
      end
      bus.Resume = (bus.State == 4'd12);
      @(posedge clk); #1;
    end
    bus.Resume = 1'b0;
    n_cmp++; n_err++;
    $display("FAIL wait_fetch: got state=%0d required state=1 within 40 cycles", bus.State);
  endtask

  // Drives one instruction from FETCH and records n cycles of outputs; after the
  // DECODE edge the IR fields are scrambled to prove the FSM uses latched copies.
  task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn, input int n);
    wait_fetch();
    bus.Op = op; bus.Func = fn;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      obs_q.push_back(observe());
      if (i >= 1) begin
        bus.Op   = 6'($urandom_range(0, 63));
        bus.Func = 6'($urandom_range(0, 63));
      end
    end
  endtask

  task automatic pulse_resume();
    bus.Resume = 1'b1;
    @(posedge clk); #1;
    obs_q.push_back(observe());
    bus.Resume = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] o;
    bus.Op = '0; bus.Func = '0; bus.Resume = 1'b0;
    rst_l = 1'b0;
    repeat (3) @(posedge clk);
    #1 o = observe();
    n_cmp++;
    if (o !== 18'h0) begin n_err++; $display("FAIL reset_hold: got %h required %h", o, 18'h0); end
    @(negedge clk); rst_l = 1'b1; #1;
    o = observe();
    n_cmp++;
    if (o !== 18'h0) begin n_err++; $display("FAIL reset_release: got %h required %h", o, 18'h0); end
    @(posedge clk); #1 o = observe();
    n_cmp++;
    if (o !== fetch_v()) begin n_err++; $display("FAIL first_fetch: got %h required %h", o, fetch_v()); end
  endtask

  task automatic test_rtype();
    logic [5:0] fns[5] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    logic [17:0] e, o;
    for (int k = 0; k < 8; k++) begin
      logic [5:0] fn;
      fn = (k < 5) ? fns[k] : fns[$urandom_range(0, 4)];
      void'(model_push(OP_RTYPE, fn));
      exec_instr(OP_RTYPE, fn, exp_q.size());
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL rtype fn=%h: got %h required %h", fn, o, e); end
      end
    end
  endtask

  task automatic test_mem();
    logic [5:0] ops[2] = '{OP_LW, OP_SW};
    logic [17:0] e, o;
    for (int k = 0; k < 2; k++) begin
      void'(model_push(ops[k], 6'($urandom_range(0, 63))));
      exec_instr(ops[k], 6'($urandom_range(0, 63)), exp_q.size());
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL mem op=%h: got %h required %h", ops[k], o, e); end
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops[2] = '{OP_BEQ, OP_BNE};
    logic [17:0] e, o;
    for (int k = 0; k < 2; k++) begin
      void'(model_push(ops[k], 6'h00));
      exec_instr(ops[k], 6'h00, exp_q.size());
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL branch op=%h: got %h required %h", ops[k], o, e); end
      end
    end
  endtask

  task automatic test_syscall();
    logic [17:0] e, o;
    void'(model_push(OP_RTYPE, FN_SYSCALL));
    exec_instr(OP_RTYPE, FN_SYSCALL, exp_q.size());
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      obs_q.push_back(observe());
      exp_q.push_back(mk(12, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    // Resume held high across a full add: one exit only, ignored in EXEC_R/WB_R.
    bus.Resume = 1'b1; bus.Op = OP_RTYPE; bus.Func = FN_ADD;
    exp_q.push_back(fetch_v());
    void'(model_push(OP_RTYPE, FN_ADD));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      obs_q.push_back(observe());
    end
    bus.Resume = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL syscall_halt_resume: got %h required %h", o, e); end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops[4] = '{6'h3F, 6'h01, 6'h10, OP_RTYPE};
    logic [17:0] e, o;
    bit halted;
    for (int k = 0; k < 4; k++) begin
      halted = model_push(ops[k], 6'h21);
      exec_instr(ops[k], 6'h21, exp_q.size());
      if (halted) begin
        exp_q.push_back(fetch_v());
        pulse_resume();
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL illegal op=%h: got %h required %h", ops[k], o, e); end
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[6] = '{OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE};
    logic [5:0] fns[5] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    logic [17:0] e, o;
    logic [5:0] op, fn;
    for (int k = 0; k < 40; k++) begin
      op = ops[$urandom_range(0, 5)];
      fn = fns[$urandom_range(0, 4)];
      void'(model_push(op, fn));
      exec_instr(op, fn, exp_q.size());
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL random op=%h fn=%h: got %h required %h", op, fn, o, e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] o;
    wait_fetch();
    bus.Op = OP_SW; bus.Func = 6'h00;
    repeat (3) @(posedge clk);
    #1 o = observe();
    n_cmp++;
    if (o !== mk(10, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0)) begin
      n_err++; $display("FAIL sw_mem_wr: got %h required %h", o, mk(10, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    end
    #2 rst_l = 1'b0;
    #1 o = observe();
    n_cmp++;
    if (o !== 18'h0) begin n_err++; $display("FAIL async_reset: got %h required %h", o, 18'h0); end
    @(posedge clk);
    @(negedge clk); rst_l = 1'b1;
    @(posedge clk); #1 o = observe();
    n_cmp++;
    if (o !== fetch_v()) begin n_err++; $display("FAIL post_reset_fetch: got %h required %h", o, fetch_v()); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_branch();
    test_syscall();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control unit for the MIPS core. It produces the control bundle (Halt, MemtoReg, MemWrite, Beq, Bne, AluOP, AluSrcB, RegWrite, RegDst) that the datapath consumes and that the CU display monitor prints. It runs instructions as a state sequence instead of single-cycle decode, and adds PcWrite/IrWrite strobes and a halt/resume handshake.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst_l  in  1  reset, asynchronous, active-low.
- Op  in  6  instruction opcode field, valid from the IR.
- Func  in  6  instruction funct field, valid from the IR.
- Resume  in  1  one-cycle pulse; leaves HALT.
- PcWrite  out  1  PC <= PC+4 strobe.
- IrWrite  out  1  IR load strobe.
- Halt  out  1  core halted.
- MemtoReg  out  1  writeback data select: memory.
- MemWrite  out  1  data memory write strobe.
- Beq  out  1  conditional PC update if Zero.
- Bne  out  1  conditional PC update if !Zero.
- AluOP  out  4  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT; 5–15 reserved.
- AluSrcB  out  1  ALU B input select: sign-extended immediate.
- RegWrite  out  1  register file write strobe.
- RegDst  out  1  destination register select: rd (else rt).
- State  out  4  current state code, for the debug monitor.
- Decision: one clock; reset is asynchronous and active-low, ports clk and rst_l.

## Operation
- Supported instructions:
  - Op 0x00 R-type, Func 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x0C syscall.
  - Op 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne.
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, WB_R=4, EXEC_I=5, WB_I=6, MEM_ADDR=7, MEM_RD=8, MEM_WB=9, MEM_WR=10, BRANCH=11, HALT=12.
- Op and Func are latched into internal registers on the DECODE cycle. Later input changes do not affect the current instruction.
- Transitions:
  - IDLE→FETCH (unconditional).
  - FETCH→DECODE.
  - DECODE→EXEC_R for R-type other than syscall.
  - DECODE→HALT for syscall.
  - DECODE→EXEC_I for addi.
  - DECODE→MEM_ADDR for lw/sw.
  - DECODE→BRANCH for beq/bne.
  - EXEC_R→WB_R→FETCH.
  - EXEC_I→WB_I→FETCH.
  - MEM_ADDR→MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD→MEM_WB→FETCH.
  - MEM_WR→FETCH.
  - BRANCH→FETCH.
  - HALT→FETCH on Resume, else stays in HALT.
- Moore outputs; any output not listed for a state is 0:
  - FETCH: IrWrite=1, PcWrite=1, AluOP=ADD.
  - EXEC_R: AluOP from the latched Func.
  - WB_R: RegWrite=1, RegDst=1, and AluOP held.
  - EXEC_I and MEM_ADDR: AluSrcB=1, AluOP=ADD.
  - WB_I: RegWrite=1, AluSrcB=1, AluOP=ADD.
  - MEM_RD: AluSrcB=1, AluOP=ADD.
  - MEM_WR: MemWrite=1, AluSrcB=1, AluOP=ADD.
  - MEM_WB: RegWrite=1, MemtoReg=1.
  - BRANCH: Beq or Bne per the latched Op, AluOP=SUB.
  - HALT: Halt=1.
- Unsupported Op, or unsupported Func under R-type: behaviour set by the macro in Configuration.

## Timing
- Outputs are registered and computed from the next state, so they change in the same edge as State.
- Reset: State=IDLE and every output 0. First edge after reset release enters FETCH.
- Latency in cycles, FETCH to the next FETCH: R-type 4, addi 4, lw 5, sw 4, beq/bne 3.
- syscall: HALT is entered 2 cycles after FETCH.
- Resume is sampled only in HALT. FETCH follows one edge later. Resume in any other state is ignored.
- Resume held high over several cycles produces exactly one exit per HALT entry; Halt is 1 for at least one cycle.
- Asserting rst_l low mid-instruction forces IDLE immediately, with all strobes deasserted asynchronously.

## Configuration
- MC_CTRL_ILLEGAL_TRAP_EN defined:
  - An unsupported opcode or funct in DECODE goes to HALT.
  - A sticky internal illegal flag is set and forces AluOP=0xF while halted.
  - Resume clears the flag.
- MC_CTRL_ILLEGAL_TRAP_EN undefined: an unsupported instruction is a NOP. DECODE→FETCH with no write strobes, 2-cycle latency.

## Structure
- Shared package mc_pkg holds:
  - the state enum encodings;
  - the AluOP constants;
  - the opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE);
  - the funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SYSCALL).
- One sub-module, mc_alu_dec: combinational mapping from latched Func to AluOP and a legal bit.

## Test plan
- Reset: hold rst_l=0, then release → State=0 with all outputs 0, then State=1 with IrWrite=1 and PcWrite=1 one edge later.
- R-type add (Op=0x00, Func=0x20) → States 1,2,3,4 in order; WB_R cycle shows RegWrite=1, RegDst=1, AluOP=0; back in FETCH after 4 cycles.
- lw (Op=0x23) → States 1,2,7,8,9; MEM_WB cycle shows MemtoReg=1, RegWrite=1. sw (Op=0x2B) → MemWrite=1 for exactly one cycle in state 10.
- beq (0x04) then bne (0x05) → a single-cycle Beq pulse with AluOP=1, then a single-cycle Bne pulse with AluOP=1, each 3 cycles total.
- syscall (Func=0x0C) → Halt=1 held for 20 cycles; Resume pulse → FETCH next edge; Resume pulse during EXEC_R has no effect.
- Op=0x3F:
  - with MC_CTRL_ILLEGAL_TRAP_EN → HALT with AluOP=0xF;
  - without it → DECODE→FETCH with no write strobe.
  - Also pull rst_l low mid-MEM_WR → MemWrite drops immediately.
